window3x3_stream: RTL and testbench



---
 rtl/window3x3_stream.sv | 124 ++++++++++++
 tb/tb_window3x3_stream.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, interior windows out,
// two internal line buffers and a single registered output stage with backpressure.
module window3x3_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  output logic [9*PIX_W-1:0] out_win,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic               frame_done,
  output logic               err_sof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [CW-1:0]        eff_col;
  logic [RW-1:0]        eff_row;
  logic                 accept;
  logic                 emit;
  logic                 at_origin;

  logic [PIX_W-1:0]     lb0 [IMG_W];
  logic [PIX_W-1:0]     lb1 [IMG_W];
  logic [PIX_W-1:0]     top_px;
  logic [PIX_W-1:0]     mid_px;

  logic [PIX_W-1:0]     win     [9];
  logic [PIX_W-1:0]     win_nxt [9];
  logic [9*PIX_W-1:0]   win_flat;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign at_origin = (col == '0) && (row == '0);

  // An accepted in_sof forces the pixel to (0,0), whatever the counters say.
  assign eff_col = in_sof ? '0 : col;
  assign eff_row = in_sof ? '0 : row;

  assign top_px = lb1[eff_col];
  assign mid_px = lb0[eff_col];

  assign emit = accept && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]     = win[3*r+1];
      win_nxt[3*r + 1] = win[3*r+2];
      win_nxt[3*r + 2] = win[3*r+2];
    end
    win_nxt[2] = top_px;
    win_nxt[5] = mid_px;
    win_nxt[8] = in_data;
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      win_flat[k*PIX_W +: PIX_W] = win_nxt[k];
    end
  end

  // Storage is never cleared; stale contents are overwritten before any window uses them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[eff_col] <= mid_px;
      lb0[eff_col] <= in_data;
      for (int k = 0; k < 9; k++) begin
        win[k] <= win_nxt[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      out_win    <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= accept && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
      err_sof    <= accept && in_sof && !at_origin;

      if (accept) begin
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
      end

      if (emit) begin
        out_win   <= win_flat;
        out_valid <= 1'b1;
        out_sof   <= (eff_row == ROW_TWO) && (eff_col == COL_TWO);
        out_eol   <= (eff_col == COL_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window3x3_stream.sv
// Bench for window3x3_stream: a 4x4 instance for the directed frames and a
// default-size instance for the random-pixel, random-backpressure frame.
module tb_window3x3_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        man_rdy;
  logic        rnd_rdy;
  logic        rand_on;
  logic        out_ready;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_out_sof, a_out_eol, a_frame_done, a_err_sof;
  logic [71:0] a_out_win;
  logic        b_in_ready, b_out_valid, b_out_sof, b_out_eol, b_frame_done, b_err_sof;
  logic [71:0] b_out_win;

  logic        s_in_ready, s_out_valid, s_out_sof, s_out_eol, s_frame_done, s_err_sof;
  logic [71:0] s_out_win;

  assign out_ready    = rand_on ? rnd_rdy : man_rdy;
  assign s_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign s_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign s_out_sof    = sel ? b_out_sof    : a_out_sof;
  assign s_out_eol    = sel ? b_out_eol    : a_out_eol;
  assign s_frame_done = sel ? b_frame_done : a_frame_done;
  assign s_err_sof    = sel ? b_err_sof    : a_err_sof;
  assign s_out_win    = sel ? b_out_win    : a_out_win;

  window3x3_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(a_in_ready), .out_win(a_out_win), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sof(a_out_sof), .out_eol(a_out_eol),
    .frame_done(a_frame_done), .err_sof(a_err_sof)
  );

  window3x3_stream u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(b_in_ready), .out_win(b_out_win), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sof(b_out_sof), .out_eol(b_out_eol),
    .frame_done(b_frame_done), .err_sof(b_err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5,
                                     input int e6, input int e7, input int e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Reference model: frame position, pixel image and expected-window queue.
  typedef struct packed {
    logic [71:0] win;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img [128][128];
  int          pr = 0, pc = 0, mw = 4, mh = 4;

  task automatic model_accept(input logic [7:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      pr = 0;
      pc = 0;
    end
    img[pr][pc] = d;
    if (pr >= 2 && pc >= 2) begin
      for (int k = 0; k < 9; k++) e.win[k*8 +: 8] = img[pr-2+k/3][pc-2+k%3];
      e.sof = (pr == 2 && pc == 2);
      e.eol = (pc == mw - 1);
      q.push_back(e);
    end
    pc++;
    if (pc == mw) begin
      pc = 0;
      pr++;
      if (pr == mh) pr = 0;
    end
  endtask

  task automatic drive_pix(input logic [7:0] d, input logic sof);
    logic acc;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    in_sof   = sof;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      #1;
      acc = s_in_ready;
      @(negedge clk);
      if (!acc) begin
        n++;
        if (n > 1000) begin
          chk("accept_timeout", 0, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (acc) model_accept(d, sof);
  endtask

  // Monitor: samples mid low phase, checks handshake, hold stability and scoreboard.
  int          n_win = 0, n_eol = 0, n_sof = 0, n_done = 0, n_err = 0, n_stall = 0;
  int          rst_cnt = 0;
  int          seen_rst = 0;
  logic        hold_p = 1'b0;
  logic [73:0] hold_v;
  logic [71:0] last_sof_win = '0;

  always @(negedge rst) rst_cnt++;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      chk("in_ready", s_in_ready, !s_out_valid || out_ready);
      if (!s_in_ready) n_stall++;
      if (hold_p && seen_rst == rst_cnt) begin
        chk("hold_valid", s_out_valid, 1);
        chk("hold_win", {s_out_win, s_out_sof, s_out_eol}, hold_v);
      end
      if (s_out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_window", s_out_win, 0);
        end else begin
          e = q.pop_front();
          chk("win", s_out_win, e.win);
          chk("win_sof", s_out_sof, e.sof);
          chk("win_eol", s_out_eol, e.eol);
        end
        n_win++;
        if (s_out_eol) n_eol++;
        if (s_out_sof) begin
          n_sof++;
          last_sof_win = s_out_win;
        end
      end
      if (s_frame_done) n_done++;
      if (s_err_sof) n_err++;
      hold_p = s_out_valid && !out_ready;
      hold_v = {s_out_win, s_out_sof, s_out_eol};
    end else begin
      hold_p = 1'b0;
    end
    seen_rst = rst_cnt;
  end

  always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

  int b_win, b_eol, b_sof, b_done, b_err, b_stall;

  task automatic snap();
    b_win = n_win; b_eol = n_eol; b_sof = n_sof;
    b_done = n_done; b_err = n_err; b_stall = n_stall;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    chk(nm, q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 16; i++) drive_pix(8'(base + i), i == 0);
  endtask

  typedef struct {
    logic [7:0]  pix;
    logic        exp_v;
    logic [71:0] exp_win;
    logic        exp_sof;
    logic        exp_eol;
    logic        exp_done;
  } vec_t;

  vec_t tv[16];

  initial begin
    for (int i = 0; i < 16; i++) tv[i] = '{8'(i), 1'b0, 72'd0, 1'b0, 1'b0, 1'b0};
    tv[10].exp_v = 1'b1; tv[10].exp_win = w9(0, 1, 2, 4, 5, 6, 8, 9, 10);   tv[10].exp_sof = 1'b1;
    tv[11].exp_v = 1'b1; tv[11].exp_win = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);  tv[11].exp_eol = 1'b1;
    tv[14].exp_v = 1'b1; tv[14].exp_win = w9(4, 5, 6, 8, 9, 10, 12, 13, 14);
    tv[15].exp_v = 1'b1; tv[15].exp_win = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    tv[15].exp_eol = 1'b1; tv[15].exp_done = 1'b1;

    rst = 1'b0; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
    man_rdy = 1'b1; rand_on = 1'b0; sel = 1'b0;
    #12;
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_win", s_out_win, 0);
    chk("rst_markers", {s_out_sof, s_out_eol, s_frame_done, s_err_sof}, 0);
    chk("rst_in_ready", s_in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // 1: ramp frame with free-running consumer, checked cycle by cycle.
    snap();
    for (int i = 0; i < 16; i++) begin
      drive_pix(tv[i].pix, i == 0);
      #2;
      chk($sformatf("t1_valid[%0d]", i), s_out_valid, tv[i].exp_v);
      if (tv[i].exp_v) begin
        chk($sformatf("t1_win[%0d]", i), s_out_win, tv[i].exp_win);
        chk($sformatf("t1_sof_eol[%0d]", i), {s_out_sof, s_out_eol}, {tv[i].exp_sof, tv[i].exp_eol});
      end
      chk($sformatf("t1_done[%0d]", i), s_frame_done, tv[i].exp_done);
    end
    drain("t1_drain");
    chk("t1_windows", n_win - b_win, 4);
    chk("t1_eol", n_eol - b_eol, 2);
    chk("t1_sof", n_sof - b_sof, 1);
    chk("t1_done", n_done - b_done, 1);

    // 2: consumer stalls 5 clocks with the first window pending.
    snap();
    for (int i = 0; i < 11; i++) drive_pix(8'(i), i == 0);
    man_rdy = 1'b0;
    fork
      begin
        for (int i = 11; i < 16; i++) drive_pix(8'(i), 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        man_rdy = 1'b1;
      end
    join
    drain("t2_drain");
    chk("t2_windows", n_win - b_win, 4);
    chk("t2_stall_cycles", n_stall - b_stall, 5);
    chk("t2_done", n_done - b_done, 1);

    // 3: two frames back to back.
    snap();
    send_frame(0);
    send_frame(100);
    drain("t3_drain");
    chk("t3_windows", n_win - b_win, 8);
    chk("t3_sof", n_sof - b_sof, 2);
    chk("t3_done", n_done - b_done, 2);
    chk("t3_second_sof_win", last_sof_win, w9(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // 4: in_sof arrives on pixel 6 of a frame and restarts it.
    snap();
    for (int i = 0; i < 6; i++) drive_pix(8'(i), i == 0);
    send_frame(50);
    drain("t4_drain");
    chk("t4_err_sof", n_err - b_err, 1);
    chk("t4_windows", n_win - b_win, 4);
    chk("t4_done", n_done - b_done, 1);
    chk("t4_sof_win", last_sof_win, w9(50, 51, 52, 54, 55, 56, 58, 59, 60));

    // 5: asynchronous reset mid-frame with a window held.
    for (int i = 0; i < 11; i++) drive_pix(8'(i), i == 0);
    man_rdy = 1'b0;
    #3;
    chk("t5_pre_valid", s_out_valid, 1);
    rst = 1'b0;
    #1;
    chk("t5_async_valid", s_out_valid, 0);
    chk("t5_async_markers", {s_out_sof, s_out_eol, s_frame_done, s_err_sof}, 0);
    chk("t5_async_win", s_out_win, 0);
    q.delete();
    pr = 0;
    pc = 0;
    @(negedge clk);
    rst = 1'b1;
    man_rdy = 1'b1;
    snap();
    send_frame(30);
    drain("t5_drain");
    chk("t5_windows", n_win - b_win, 4);
    chk("t5_done", n_done - b_done, 1);

    // 6: default-size instance, random pixels and random backpressure.
    @(negedge clk);
    sel = 1'b1;
    mw = 128;
    mh = 128;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    pr = 0;
    pc = 0;
    rand_on = 1'b1;
    snap();
    for (int i = 0; i < 128 * 128; i++) drive_pix(8'($urandom_range(0, 255)), i == 0);
    drain("t6_drain");
    rand_on = 1'b0;
    chk("t6_windows", n_win - b_win, 15876);
    chk("t6_eol", n_eol - b_eol, 126);
    chk("t6_sof", n_sof - b_sof, 1);
    chk("t6_done", n_done - b_done, 1);
    chk("t6_err", n_err - b_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
